// File: rtl/calc_pkg.sv
// calc_pkg: shared calculator constants, command/move codes and controller states
package calc_pkg;
  localparam int DATA_W = 32;
  localparam int DEPTH = 512;
  localparam int CNT_W = 10;
  typedef enum logic [2:0] {CMD_ADD, CMD_SUB, CMD_MUL, CMD_DIV, CMD_MOD, CMD_POP, CMD_DUP, CMD_SWP} cmd_t;
  localparam logic [1:0] ST_NO_MOV = 2'd0;
  localparam logic [1:0] ST_MOV_UP = 2'd1;
  localparam logic [1:0] ST_MOV_DN = 2'd2;
  typedef enum logic [2:0] {IDLE, CHECK, DIV_WAIT, ISSUE, MEM_WAIT, MEM_WAIT2} state_t;
  function automatic logic cmd_ok(cmd_t c, logic [CNT_W-1:0] n, logic b_zero);
    return c == CMD_POP ? n != '0 :
           c == CMD_DUP ? (n != '0 && n < CNT_W'(DEPTH)) :
           (n >= CNT_W'(2) && !((c == CMD_DIV || c == CMD_MOD) && b_zero));
  endfunction
endpackage

// File: rtl/calc_exec_ctrl_if.sv
// calc_exec_ctrl_if: exec request handshake plus stack command/status bus
interface calc_exec_ctrl_if;
  import calc_pkg::*;
  logic start;
  cmd_t cmd;
  logic busy, done, err, st_en, st_ready;
  logic [1:0] st_write_elems_cnt, st_top_mov;
  logic [DATA_W-1:0] st_write_elem0, st_write_elem1, st_top0, st_top1;
  logic [CNT_W-1:0] st_elems_cnt;
  modport master(input start, cmd, st_elems_cnt, st_top0, st_top1, st_ready,
                 output busy, done, err, st_en, st_write_elems_cnt, st_write_elem0, st_write_elem1, st_top_mov);
  modport slave(output start, cmd, st_elems_cnt, st_top0, st_top1, st_ready,
                input busy, done, err, st_en, st_write_elems_cnt, st_write_elem0, st_write_elem1, st_top_mov);
endinterface

// File: rtl/calc_divider.sv
// calc_divider: signed iterative restoring divider, one quotient bit per cycle, sign fixup last
module calc_divider
  import calc_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              go,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              valid,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);
  localparam int CW = $clog2(DATA_W + 1);
  logic [DATA_W-1:0] r_q, q_q, d_q;
  logic [DATA_W:0] sh;
  logic [CW-1:0] cnt;
  logic neg_q, neg_r, ge;
  assign sh = {r_q, q_q[DATA_W-1]};
  assign ge = sh >= {1'b0, d_q};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      {busy, valid, neg_q, neg_r} <= '0;
      {r_q, q_q, d_q, quotient, remainder} <= '0;
      cnt <= '0;
    end else begin
      valid <= 1'b0;
      if (clear) busy <= 1'b0;
      else if (go) begin
        busy <= 1'b1;
        cnt <= '0;
        r_q <= '0;
        q_q <= dividend[DATA_W-1] ? -dividend : dividend;
        d_q <= divisor[DATA_W-1] ? -divisor : divisor;
        neg_q <= dividend[DATA_W-1] ^ divisor[DATA_W-1];
        neg_r <= dividend[DATA_W-1];
      end else if (busy && cnt != CW'(DATA_W)) begin
        r_q <= ge ? sh[DATA_W-1:0] - d_q : sh[DATA_W-1:0];
        q_q <= {q_q[DATA_W-2:0], ge};
        cnt <= cnt + 1'b1;
      end else if (busy) begin
        busy <= 1'b0;
        valid <= 1'b1;
        quotient <= neg_q ? -q_q : q_q;
        remainder <= neg_r ? -r_q : r_q;
      end
    end
endmodule

// File: rtl/calc_exec_ctrl.sv
// calc_exec_ctrl: EXEC sequencer -- precondition check, compute, one-shot stack write/move
module calc_exec_ctrl
  import calc_pkg::*;
(
  input logic clk,
  input logic reset_n,
  input logic clear,
  calc_exec_ctrl_if.master bus
);
  state_t state, nxt;
  cmd_t cmd_q;
  logic [DATA_W-1:0] a_q, b_q, res, e0_q, e1_q, quo, rem;
  logic [CNT_W-1:0] n_q;
  logic [1:0] wcnt_q, mov_q;
  logic err_q, ok, is_div, div_go, div_valid, div_busy, load;
  assign is_div = cmd_q == CMD_DIV || cmd_q == CMD_MOD;
  assign ok = cmd_ok(cmd_q, n_q, b_q == '0);
  assign div_go = !clear && state == CHECK && ok && is_div;
  assign load = !clear && ((state == CHECK && ok && !is_div) || (state == DIV_WAIT && div_valid));
  assign res = cmd_q == CMD_ADD ? a_q + b_q :
               cmd_q == CMD_SUB ? a_q - b_q :
               cmd_q == CMD_MUL ? a_q * b_q :
               cmd_q == CMD_DIV ? quo :
               cmd_q == CMD_MOD ? rem :
               cmd_q == CMD_SWP ? a_q : b_q;
  calc_divider u_div (
    .clk(clk), .reset_n(reset_n), .clear(clear), .go(div_go), .dividend(a_q), .divisor(b_q),
    .busy(div_busy), .valid(div_valid), .quotient(quo), .remainder(rem)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = bus.start ? CHECK : IDLE;
      CHECK:     nxt = !ok ? IDLE : is_div ? DIV_WAIT : ISSUE;
      DIV_WAIT:  nxt = div_valid ? ISSUE : div_busy ? DIV_WAIT : IDLE;
      ISSUE:     nxt = MEM_WAIT;
      MEM_WAIT:  nxt = MEM_WAIT2;
      MEM_WAIT2: nxt = bus.st_ready ? IDLE : MEM_WAIT2;
      default:   nxt = IDLE;
    endcase
    if (clear) nxt = IDLE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cmd_q <= CMD_ADD;
      {a_q, b_q, e0_q, e1_q} <= '0;
      n_q <= '0;
      {wcnt_q, mov_q} <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE && bus.start && !clear) begin
        cmd_q <= bus.cmd;
        a_q <= bus.st_top1;
        b_q <= bus.st_top0;
        n_q <= bus.st_elems_cnt;
      end
      err_q <= !clear && state == CHECK && !ok;
      if (load) begin
        e0_q <= res;
        e1_q <= cmd_q == CMD_SWP ? b_q : e1_q;
        wcnt_q <= cmd_q == CMD_SWP ? 2'd2 : cmd_q == CMD_POP ? 2'd0 : 2'd1;
        mov_q <= cmd_q == CMD_SWP ? ST_NO_MOV : cmd_q == CMD_DUP ? ST_MOV_UP : ST_MOV_DN;
      end
    end
  assign bus.busy = state != IDLE || err_q;
  assign bus.done = !clear && (err_q || (state == MEM_WAIT2 && bus.st_ready));
  assign bus.err = !clear && err_q;
  assign bus.st_en = state == ISSUE;
  assign bus.st_write_elems_cnt = wcnt_q;
  assign bus.st_write_elem0 = e0_q;
  assign bus.st_write_elem1 = e1_q;
  assign bus.st_top_mov = mov_q;
endmodule

// File: tb/tb_calc_exec_ctrl.sv
// tb_calc_exec_ctrl: vector table with expectation queue, plus clear/reset/busy-start sequences
module tb_calc_exec_ctrl;
  import calc_pkg::*;
  typedef struct {
    cmd_t cmd;
    logic [9:0] n;
    logic [31:0] t1, t0;
    logic exp_err;
    logic [1:0] wcnt;
    logic [31:0] e0, e1;
    logic [1:0] mov;
    int en_lat, done_lat;
  } vec_t;
  logic clk = 0, reset_n = 0, clear = 0;
  int checks = 0, failures = 0, rdy_cnt;
  vec_t exp_q[$];
  calc_exec_ctrl_if bus();
  calc_exec_ctrl dut (.clk(clk), .reset_n(reset_n), .clear(clear), .bus(bus));
  always #5 clk = ~clk;
  // stack holds st_ready low for two cycles after a two-element write
  assign bus.st_ready = rdy_cnt == 0;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) rdy_cnt <= 0;
    else if (bus.st_en && bus.st_write_elems_cnt == 2'd2) rdy_cnt <= 2;
    else if (rdy_cnt > 0) rdy_cnt <= rdy_cnt - 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input cmd_t c, input logic [9:0] n, input logic [31:0] t1, input logic [31:0] t0);
    @(negedge clk);
    bus.cmd = c;
    bus.st_elems_cnt = n;
    bus.st_top1 = t1;
    bus.st_top0 = t0;
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
  endtask

  task automatic run(input vec_t v, input int idx);
    int en_n = 0, en_k = -1, done_k = -1;
    logic err_s = 0;
    logic [1:0] wc = 0, mv = 0;
    logic [31:0] e0 = 0, e1 = 0;
    vec_t x;
    string p;
    exp_q.push_back(v);
    drive(v.cmd, v.n, v.t1, v.t0);
    for (int k = 1; k <= 60 && done_k < 0; k++) begin
      if (bus.st_en) begin
        en_n++;
        en_k = k;
        wc = bus.st_write_elems_cnt;
        mv = bus.st_top_mov;
        e0 = bus.st_write_elem0;
        e1 = bus.st_write_elem1;
      end
      if (bus.done) begin
        done_k = k;
        err_s = bus.err;
      end
      if (done_k < 0) @(negedge clk);
    end
    x = exp_q.pop_front();
    p = $sformatf("v%0d", idx);
    chk({p, "_done_lat"}, done_k, x.done_lat);
    chk({p, "_err"}, {31'd0, err_s}, {31'd0, x.exp_err});
    chk({p, "_en_count"}, en_n, x.exp_err ? 0 : 1);
    if (!x.exp_err) begin
      chk({p, "_en_lat"}, en_k, x.en_lat);
      chk({p, "_wcnt"}, {30'd0, wc}, {30'd0, x.wcnt});
      chk({p, "_mov"}, {30'd0, mv}, {30'd0, x.mov});
      if (x.wcnt != 2'd0) chk({p, "_elem0"}, e0, x.e0);
      if (x.wcnt == 2'd2) chk({p, "_elem1"}, e1, x.e1);
    end
  endtask

  initial begin
    vec_t vecs[$];
    int en, dn;
    logic [31:0] e;
    vecs.push_back('{CMD_ADD, 10'd2, 32'd7, 32'd5, 1'b0, 2'd1, 32'd12, 32'd0, ST_MOV_DN, 2, 4});
    vecs.push_back('{CMD_SUB, 10'd3, 32'd5, 32'd9, 1'b0, 2'd1, 32'hFFFFFFFC, 32'd0, ST_MOV_DN, 2, 4});
    vecs.push_back('{CMD_MUL, 10'd2, 32'h00010000, 32'h00010003, 1'b0, 2'd1, 32'h00030000, 32'd0, ST_MOV_DN, 2, 4});
    vecs.push_back('{CMD_ADD, 10'd2, 32'h7FFFFFFF, 32'd1, 1'b0, 2'd1, 32'h80000000, 32'd0, ST_MOV_DN, 2, 4});
    vecs.push_back('{CMD_DIV, 10'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 2'd1, 32'hFFFFFFFD, 32'd0, ST_MOV_DN, 36, 38});
    vecs.push_back('{CMD_MOD, 10'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 2'd1, 32'hFFFFFFFF, 32'd0, ST_MOV_DN, 36, 38});
    vecs.push_back('{CMD_DIV, 10'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 2'd1, 32'h80000000, 32'd0, ST_MOV_DN, 36, 38});
    vecs.push_back('{CMD_MOD, 10'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 2'd1, 32'd0, 32'd0, ST_MOV_DN, 36, 38});
    vecs.push_back('{CMD_DIV, 10'd4, 32'd100, 32'hFFFFFFF9, 1'b0, 2'd1, 32'hFFFFFFF2, 32'd0, ST_MOV_DN, 36, 38});
    vecs.push_back('{CMD_MOD, 10'd4, 32'd100, 32'hFFFFFFF9, 1'b0, 2'd1, 32'd2, 32'd0, ST_MOV_DN, 36, 38});
    vecs.push_back('{CMD_DIV, 10'd2, 32'd9, 32'd0, 1'b1, 2'd0, 32'd0, 32'd0, ST_NO_MOV, 0, 2});
    vecs.push_back('{CMD_DIV, 10'd1, 32'd9, 32'd3, 1'b1, 2'd0, 32'd0, 32'd0, ST_NO_MOV, 0, 2});
    vecs.push_back('{CMD_DUP, 10'd512, 32'd1, 32'd2, 1'b1, 2'd0, 32'd0, 32'd0, ST_NO_MOV, 0, 2});
    vecs.push_back('{CMD_DUP, 10'd511, 32'd1, 32'h55, 1'b0, 2'd1, 32'h55, 32'd0, ST_MOV_UP, 2, 4});
    vecs.push_back('{CMD_POP, 10'd0, 32'd1, 32'd2, 1'b1, 2'd0, 32'd0, 32'd0, ST_NO_MOV, 0, 2});
    vecs.push_back('{CMD_POP, 10'd1, 32'd1, 32'd2, 1'b0, 2'd0, 32'd0, 32'd0, ST_MOV_DN, 2, 4});
    vecs.push_back('{CMD_SWP, 10'd2, 32'hA, 32'hB, 1'b0, 2'd2, 32'hA, 32'hB, ST_NO_MOV, 2, 5});
    vecs.push_back('{CMD_SWP, 10'd1, 32'hA, 32'hB, 1'b1, 2'd0, 32'd0, 32'd0, ST_NO_MOV, 0, 2});
    bus.start = 0;
    bus.cmd = CMD_ADD;
    bus.st_elems_cnt = 0;
    bus.st_top0 = 0;
    bus.st_top1 = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_done", {31'd0, bus.done}, 0);
    chk("rst_err", {31'd0, bus.err}, 0);
    chk("rst_st_en", {31'd0, bus.st_en}, 0);
    chk("rst_wcnt", {30'd0, bus.st_write_elems_cnt}, 0);
    chk("rst_mov", {30'd0, bus.st_top_mov}, {30'd0, ST_NO_MOV});
    reset_n = 1;
    foreach (vecs[i]) run(vecs[i], i);

    drive(CMD_DIV, 10'd2, 32'hFFFFFFF9, 32'd2);
    repeat (8) @(negedge clk);
    clear = 1;
    @(negedge clk);
    clear = 0;
    chk("clr_busy", {31'd0, bus.busy}, 0);
    en = 0;
    dn = 0;
    for (int k = 0; k < 45; k++) begin
      if (bus.st_en) en++;
      if (bus.done) dn++;
      @(negedge clk);
    end
    chk("clr_no_st_en", en, 0);
    chk("clr_no_done", dn, 0);
    run(vecs[0], 100);

    @(negedge clk);
    bus.cmd = CMD_ADD;
    bus.start = 1;
    clear = 1;
    @(negedge clk);
    bus.start = 0;
    clear = 0;
    chk("start_clear_busy", {31'd0, bus.busy}, 0);

    drive(CMD_SWP, 10'd2, 32'hA, 32'hB);
    repeat (3) @(negedge clk);
    chk("rst_mid_busy", {31'd0, bus.busy}, 1);
    reset_n = 0;
    #1;
    chk("rst_mid_busy0", {31'd0, bus.busy}, 0);
    chk("rst_mid_done", {31'd0, bus.done}, 0);
    chk("rst_mid_st_en", {31'd0, bus.st_en}, 0);
    chk("rst_mid_wcnt", {30'd0, bus.st_write_elems_cnt}, 0);
    chk("rst_mid_elem0", bus.st_write_elem0, 0);
    chk("rst_mid_elem1", bus.st_write_elem1, 0);
    @(negedge clk);
    reset_n = 1;

    drive(CMD_ADD, 10'd2, 32'd7, 32'd5);
    en = 0;
    dn = 0;
    e = 0;
    for (int k = 1; k <= 20; k++) begin
      bus.start = k <= 3;
      if (k <= 3) bus.cmd = CMD_DUP;
      else bus.cmd = CMD_ADD;
      if (bus.st_en) begin
        en++;
        e = bus.st_write_elem0;
      end
      if (bus.done) dn++;
      @(negedge clk);
    end
    chk("busy_start_done", dn, 1);
    chk("busy_start_st_en", en, 1);
    chk("busy_start_elem0", e, 32'd12);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
